// File: rtl/stack_instr_sequencer.sv
// Instruction-issue front end for the stack datapath: fetches 16-bit words, decodes them and
// drives one stack/ALU operation per EXEC cycle, resolving BEQ/BEZ from the datapath's ALU_out.
module stack_instr_sequencer #(
    parameter int PC_W        = 8,
    parameter int RESET_PC    = 0,
    parameter int HALT_ON_OVF = 1
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_data,
    output logic [2:0]      stackOP,
    output logic [3:0]      aluOP,
    output logic            mux_selector,
    output logic [15:0]     immediate,
    input  logic [15:0]     ALU_out,
    input  logic            Overflow,
    output logic            busy,
    output logic            halted,
    output logic            error,
    output logic [PC_W-1:0] pc
);

    localparam logic [3:0] OP_NOP  = 4'h0, OP_PUSHI = 4'h1, OP_ADD  = 4'h2, OP_SUB  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4, OP_DUP   = 4'h5, OP_DROP = 4'h6, OP_OVER = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8, OP_SWAP  = 4'h9, OP_BEQ  = 4'hA, OP_BEZ  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC, OP_ILL0  = 4'hD, OP_ILL1 = 4'hE, OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_FETCH_IMM, S_EXEC, S_HALTED
    } state_t;

    state_t          state, state_nx;
    logic [15:0]     instr;
    logic [PC_W-1:0] br_addr;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] jmp_target;
    logic            gap;
    logic            accept;
    logic            ovf_halt;
    logic            taken;
    logic [3:0]      fetch_op;
    logic [3:0]      op;
    logic            unused_alu;

    // gap forces one idle request cycle after every accepted word
    assign imem_req   = (state == S_FETCH || state == S_FETCH_IMM) && !gap;
    assign imem_addr  = imem_req ? pc : '0;
    assign accept     = imem_req && imem_valid;
    assign fetch_op   = imem_data[15:12];
    assign op         = instr[15:12];
    assign busy       = (state == S_FETCH) || (state == S_FETCH_IMM) || (state == S_EXEC);
    assign halted     = (state == S_HALTED);
    assign ovf_halt   = (HALT_ON_OVF != 0) && Overflow;
    assign taken      = (op == OP_BEQ || op == OP_BEZ) && ALU_out[0];
    assign br_target  = br_addr + PC_W'({{20{instr[11]}}, instr[11:0]});
    assign jmp_target = PC_W'(imem_data[11:0]);
    assign unused_alu = ^ALU_out[15:1];

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_HALTED: if (start) state_nx = S_FETCH;
            S_FETCH: begin
                if (accept) begin
                    case (fetch_op)
                        OP_NOP, OP_JMP:            state_nx = S_FETCH;
                        OP_PUSHI:                  state_nx = S_FETCH_IMM;
                        OP_HALT, OP_ILL0, OP_ILL1: state_nx = S_HALTED;
                        default:                   state_nx = S_EXEC;
                    endcase
                end
            end
            S_FETCH_IMM: if (accept) state_nx = S_EXEC;
            S_EXEC:      state_nx = ovf_halt ? S_HALTED : S_FETCH;
            default:     state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        stackOP      = 3'd0;
        aluOP        = 4'd0;
        mux_selector = 1'b0;
        if (state == S_EXEC) begin
            case (op)
                OP_PUSHI: begin stackOP = 3'd1; mux_selector = 1'b1; end
                OP_ADD:   begin stackOP = 3'd2; aluOP = 4'd0; end
                OP_SUB:   begin stackOP = 3'd2; aluOP = 4'd1; end
                OP_OR:    begin stackOP = 3'd2; aluOP = 4'd3; end
                OP_DUP:   begin stackOP = 3'd1; aluOP = 4'd5; end
                OP_DROP:  stackOP = 3'd3;
                OP_OVER:  begin stackOP = 3'd1; aluOP = 4'd6; end
                OP_SLT:   begin stackOP = 3'd2; aluOP = 4'd9; end
                OP_SWAP:  stackOP = 3'd5;
                OP_BEQ:   begin stackOP = 3'd4; aluOP = 4'd7; end
                OP_BEZ:   begin stackOP = 3'd4; aluOP = 4'd8; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pc        <= PC_W'(RESET_PC);
            instr     <= 16'h0;
            br_addr   <= '0;
            immediate <= 16'h0;
            error     <= 1'b0;
            gap       <= 1'b0;
        end else begin
            state <= state_nx;
            gap   <= accept;
            case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc    <= PC_W'(RESET_PC);
                        error <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (accept) begin
                        instr   <= imem_data;
                        br_addr <= pc;
                        pc      <= (fetch_op == OP_JMP) ? jmp_target : pc + 1'b1;
                        if (fetch_op == OP_ILL0 || fetch_op == OP_ILL1) error <= 1'b1;
                    end
                end
                S_FETCH_IMM: begin
                    if (accept) begin
                        immediate <= imem_data;
                        pc        <= pc + 1'b1;
                    end
                end
                S_EXEC: begin
                    // branch redirect and overflow halt are independent: the op completes either way
                    if (taken)    pc    <= br_target;
                    if (ovf_halt) error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
